// File: rtl/axi_read_arbiter_if.sv
// AXI read channel bundle (AR + R) shared by the two upstream masters
// and the downstream slave port of the read arbiter.
interface axi_read_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [ID_W-1:0]   arid;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  // Side that issues read requests and consumes read data
  modport master (
    output arvalid, araddr, arlen, arid, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  // Side that accepts read requests and returns read data
  modport slave (
    input  arvalid, araddr, arlen, arid, rready,
    output arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// Two-master AXI read arbiter: ICache refill (m0) and DCache miss (m1)
// share one downstream read port. One burst is outstanding at a time,
// ties are broken by a round-robin priority bit, and a sticky error flags
// bursts whose beat count disagrees with the requested arlen.
module axi_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  axi_read_arbiter_if.slave  m0,
  axi_read_arbiter_if.slave  m1,
  axi_read_arbiter_if.master s,
  output logic               busy,
  output logic               err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] AR   = 2'd1;
  localparam logic [1:0] R    = 2'd2;

  logic [1:0] state;
  logic       gnt;
  logic       prio;
  logic [7:0] cnt;
  logic [7:0] len_q;

  logic       in_ar;
  logic       in_r;
  logic       pick;
  logic       ar_hs;
  logic       r_beat;
  logic       len_bad;

  assign in_ar  = (state == AR);
  assign in_r   = (state == R);
  // Sole requester wins; on a tie prio selects the master.
  assign pick   = (m0.arvalid & m1.arvalid) ? prio : m1.arvalid;
  assign ar_hs  = s.arvalid & s.arready;
  assign r_beat = s.rvalid & s.rready;
  // Early rlast, or the expected last beat arriving without rlast.
  assign len_bad = (s.rlast & (cnt != len_q)) | (~s.rlast & (cnt == len_q));
  assign busy   = (state != IDLE);

  // Route the granted master's AR channel downstream while in AR only.
  always_comb begin
    s.arvalid  = 1'b0;
    s.araddr   = {ADDR_W{1'b0}};
    s.arlen    = 8'd0;
    s.arid     = {ID_W{1'b0}};
    m0.arready = 1'b0;
    m1.arready = 1'b0;
    if (in_ar) begin
      if (gnt) begin
        s.arvalid  = m1.arvalid;
        s.araddr   = m1.araddr;
        s.arlen    = m1.arlen;
        s.arid     = m1.arid;
        m1.arready = s.arready;
      end else begin
        s.arvalid  = m0.arvalid;
        s.araddr   = m0.araddr;
        s.arlen    = m0.arlen;
        s.arid     = m0.arid;
        m0.arready = s.arready;
      end
    end
  end

  // Route R data to both masters; only rvalid/rready follow the grant.
  // Data outputs are forced low while reset is held.
  always_comb begin
    s.rready  = in_r & (gnt ? m1.rready : m0.rready);
    m0.rvalid = in_r & ~gnt & s.rvalid;
    m1.rvalid = in_r &  gnt & s.rvalid;
    m0.rdata  = rst ? s.rdata : {DATA_W{1'b0}};
    m1.rdata  = rst ? s.rdata : {DATA_W{1'b0}};
    m0.rresp  = rst ? s.rresp : 2'b00;
    m1.rresp  = rst ? s.rresp : 2'b00;
    m0.rlast  = rst & s.rlast;
    m1.rlast  = rst & s.rlast;
  end

  // Transaction FSM: grant in IDLE, address handshake in AR, beats in R.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= 1'b0;
      prio  <= 1'b0;
      cnt   <= 8'd0;
      len_q <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (m0.arvalid | m1.arvalid) begin
            gnt   <= pick;
            prio  <= ~pick;
            state <= AR;
          end
        end
        AR: begin
          if (ar_hs) begin
            len_q <= gnt ? m1.arlen : m0.arlen;
            cnt   <= 8'd0;
            state <= R;
          end
        end
        R: begin
          if (r_beat) begin
            cnt <= cnt + 8'd1;
            if (s.rlast) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky burst-length violation flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (in_r & r_beat & len_bad) begin
      err <= 1'b1;
    end
  end

endmodule
